// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of one synchronous memory port.
// One transaction at a time; reads wait READ_LAT cycles for mem_din.
module mem_arbiter #(
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [23:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_ack,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [23:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ack,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        grant,
    output logic        mem_enable,
    output logic        mem_write,
    output logic [23:0] mem_addr,
    output logic [31:0] mem_dout,
    input  logic [31:0] mem_din
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t      state, state_n;
    logic        last_grant, last_grant_n;
    logic        grant_n;
    logic [1:0]  cnt, cnt_n;
    logic        lat_we, lat_we_n;
    logic [23:0] addr_n;
    logic [31:0] dout_n;
    logic [31:0] rdata_n;
    logic        en_n, wr_n;
    logic        ack0_n, ack1_n;
    logic        busy_n;
    logic        pick;

    // On contention the port that did not win last time goes next.
    assign pick = (p0_req && p1_req) ? ~last_grant : p1_req;

    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        grant_n      = grant;
        cnt_n        = cnt;
        lat_we_n     = lat_we;
        addr_n       = mem_addr;
        dout_n       = mem_dout;
        rdata_n      = rdata;
        en_n         = 1'b0;
        wr_n         = 1'b0;
        ack0_n       = 1'b0;
        ack1_n       = 1'b0;
        unique case (state)
            IDLE: begin
                if (p0_req || p1_req) begin
                    grant_n  = pick;
                    lat_we_n = pick ? p1_we : p0_we;
                    addr_n   = pick ? p1_addr : p0_addr;
                    dout_n   = pick ? p1_wdata : p0_wdata;
                    en_n     = 1'b1;
                    wr_n     = lat_we_n;
                    state_n  = ISSUE;
                end
            end
            ISSUE: begin
                if (lat_we) begin
                    ack0_n  = ~grant;
                    ack1_n  = grant;
                    state_n = DONE;
                end else begin
                    cnt_n   = 2'(READ_LAT - 1);
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 2'd0) begin
                    rdata_n = mem_din;
                    ack0_n  = ~grant;
                    ack1_n  = grant;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt - 2'd1;
                end
            end
            DONE: begin
                last_grant_n = grant;
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            cnt        <= 2'd0;
            lat_we     <= 1'b0;
            mem_addr   <= 24'd0;
            mem_dout   <= 32'd0;
            rdata      <= 32'd0;
            mem_enable <= 1'b0;
            mem_write  <= 1'b0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
            grant      <= grant_n;
            cnt        <= cnt_n;
            lat_we     <= lat_we_n;
            mem_addr   <= addr_n;
            mem_dout   <= dout_n;
            rdata      <= rdata_n;
            mem_enable <= en_n;
            mem_write  <= wr_n;
            p0_ack     <= ack0_n;
            p1_ack     <= ack1_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: two instances, READ_LAT=3 and READ_LAT=1.
// Stimulus pushes expected accesses/acks; a negedge monitor pops and compares.
module tb_mem_arbiter;

    typedef struct {
        int          t;
        int          port;
        bit          we;
        logic [23:0] a;
        logic [31:0] wd;
    } acc_t;

    typedef struct {
        int          t;
        int          port;
        logic [31:0] rd;
    } ack_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic [1:0]  preq [2];
    logic [1:0]  pwe [2];
    logic [23:0] paddr [2][2];
    logic [31:0] pwd [2][2];
    logic [1:0]  ack [2];
    logic [31:0] rdata [2];
    logic [1:0]  busy, grant, men, mw;
    logic [23:0] maddr [2];
    logic [31:0] mdout [2];
    logic [31:0] mdin [2];
    logic [31:0] pipe [2][3];
    logic [31:0] mem [256];
    logic [31:0] rd_model [2];

    acc_t acc_q [2][$];
    ack_t ack_q [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.READ_LAT(3)) u0 (
        .clk(clk), .reset(reset),
        .p0_req(preq[0][0]), .p0_we(pwe[0][0]),
        .p0_addr(paddr[0][0]), .p0_wdata(pwd[0][0]), .p0_ack(ack[0][0]),
        .p1_req(preq[0][1]), .p1_we(pwe[0][1]),
        .p1_addr(paddr[0][1]), .p1_wdata(pwd[0][1]), .p1_ack(ack[0][1]),
        .rdata(rdata[0]), .busy(busy[0]), .grant(grant[0]),
        .mem_enable(men[0]), .mem_write(mw[0]),
        .mem_addr(maddr[0]), .mem_dout(mdout[0]), .mem_din(mdin[0])
    );

    mem_arbiter #(.READ_LAT(1)) u1 (
        .clk(clk), .reset(reset),
        .p0_req(preq[1][0]), .p0_we(pwe[1][0]),
        .p0_addr(paddr[1][0]), .p0_wdata(pwd[1][0]), .p0_ack(ack[1][0]),
        .p1_req(preq[1][1]), .p1_we(pwe[1][1]),
        .p1_addr(paddr[1][1]), .p1_wdata(pwd[1][1]), .p1_ack(ack[1][1]),
        .rdata(rdata[1]), .busy(busy[1]), .grant(grant[1]),
        .mem_enable(men[1]), .mem_write(mw[1]),
        .mem_addr(maddr[1]), .mem_dout(mdout[1]), .mem_din(mdin[1])
    );

    // Memory model: data appears READ_LAT cycles after the sampled enable
    assign mdin[0] = pipe[0][2];
    assign mdin[1] = pipe[1][0];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (men[d] && mw[d]) mem[maddr[d][7:0]] <= mdout[d];
            pipe[d][0] <= (men[d] && !mw[d]) ? mem[maddr[d][7:0]]
                                             : 32'hBAD00000 + 32'(cyc);
            pipe[d][1] <= pipe[d][0];
            pipe[d][2] <= pipe[d][1];
        end
    end

    function automatic int lat(input int d);
        return (d == 0) ? 3 : 1;
    endfunction

    task automatic chk(input bit ok, input string name, input string info);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: %s", name, info);
        end
    endtask

    // Monitor: every strobe and every ack must match the head of its queue
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mw[d] && !men[d])
                chk(1'b0, "write_no_enable", $sformatf("dut%0d cyc=%0d", d, cyc));
            if (men[d]) begin
                if (acc_q[d].size() == 0) begin
                    chk(1'b0, "acc_unexpected",
                        $sformatf("dut%0d cyc=%0d a=%h", d, cyc, maddr[d]));
                end else begin
                    acc_t e;
                    e = acc_q[d].pop_front();
                    chk(cyc == e.t && int'(grant[d]) == e.port && mw[d] == e.we &&
                        maddr[d] == e.a && mdout[d] == e.wd && busy[d],
                        "access",
                        $sformatf("dut%0d got cyc=%0d g=%0d w=%0d a=%h d=%h b=%0d want cyc=%0d g=%0d w=%0d a=%h d=%h b=1",
                                  d, cyc, grant[d], mw[d], maddr[d], mdout[d], busy[d],
                                  e.t, e.port, e.we, e.a, e.wd));
                end
            end
            if (ack[d] != 2'b00) begin
                if (ack_q[d].size() == 0) begin
                    chk(1'b0, "ack_unexpected",
                        $sformatf("dut%0d cyc=%0d ack=%b", d, cyc, ack[d]));
                end else begin
                    ack_t e;
                    logic [1:0] want;
                    e = ack_q[d].pop_front();
                    want = (e.port == 0) ? 2'b01 : 2'b10;
                    chk(cyc == e.t && ack[d] == want && rdata[d] == e.rd, "ack",
                        $sformatf("dut%0d got cyc=%0d ack=%b rdata=%h want cyc=%0d ack=%b rdata=%h",
                                  d, cyc, ack[d], rdata[d], e.t, want, e.rd));
                end
            end
        end
    end

    task automatic expect_txn(input int d, input int p, input bit we,
                              input logic [23:0] a, input logic [31:0] wd,
                              input logic [31:0] r, input int t, input bit acked);
        acc_t x;
        ack_t y;
        x = '{t + 1, p, we, a, wd};
        acc_q[d].push_back(x);
        if (acked) begin
            if (!we) rd_model[d] = r;
            y = '{we ? t + 2 : t + 2 + lat(d), p, rd_model[d]};
            ack_q[d].push_back(y);
        end
    endtask

    task automatic drive(input int d, input int p, input bit req, input bit we,
                         input logic [23:0] a, input logic [31:0] wd);
        preq[d][p]  = req;
        pwe[d][p]   = we;
        paddr[d][p] = a;
        pwd[d][p]   = wd;
    endtask

    task automatic wait_ack(input int d, input int p);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = ack[d][p];
        end
        chk(got, "ack_timeout", $sformatf("dut%0d port%0d cyc=%0d", d, p, cyc));
    endtask

    // Single transaction; caller guarantees the DUT is idle next cycle
    task automatic run1(input int d, input int p, input bit we,
                        input logic [23:0] a, input logic [31:0] wd,
                        input logic [31:0] r);
        @(negedge clk);
        drive(d, p, 1'b1, we, a, wd);
        expect_txn(d, p, we, a, wd, r, cyc, 1'b1);
        wait_ack(d, p);
        preq[d][p] = 1'b0;
    endtask

    // Both ports hold requests for n transactions, port 0 wins first
    task automatic both(input int d, input int n, input bit rel,
                        input logic [1:0] we,
                        input logic [23:0] a0, input logic [23:0] a1,
                        input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] r0, input logic [31:0] r1);
        int t;
        int p = 0;
        @(negedge clk);
        if (rel) reset = 1'b0;
        drive(d, 0, 1'b1, we[0], a0, w0);
        drive(d, 1, 1'b1, we[1], a1, w1);
        t = cyc;
        for (int k = 0; k < n; k++) begin
            expect_txn(d, p, we[p], p ? a1 : a0, p ? w1 : w0,
                       p ? r1 : r0, t, 1'b1);
            t += we[p] ? 3 : 3 + lat(d);
            p ^= 1;
        end
        while (cyc < t - 1) @(negedge clk);
        preq[d] = 2'b00;
    endtask

    task automatic check_idle_zero(input string name);
        for (int d = 0; d < 2; d++)
            chk(busy[d] == 0 && ack[d] == 0 && men[d] == 0 && mw[d] == 0 &&
                grant[d] == 0 && maddr[d] == 0 && mdout[d] == 0 && rdata[d] == 0,
                name,
                $sformatf("dut%0d cyc=%0d b=%0d ack=%b en=%0d w=%0d g=%0d a=%h d=%h rd=%h",
                          d, cyc, busy[d], ack[d], men[d], mw[d], grant[d],
                          maddr[d], mdout[d], rdata[d]));
    endtask

    initial begin
        int t;
        rd_model[0] = '0;
        rd_model[1] = '0;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) drive(d, p, 1'b0, 1'b0, '0, '0);
        drive(0, 0, 1'b1, 1'b1, 24'h000001, 32'h11111111);
        drive(0, 1, 1'b1, 1'b1, 24'h000002, 32'h22222222);

        repeat (3) begin
            @(negedge clk);
            check_idle_zero("reset_out");
        end

        both(0, 4, 1'b1, 2'b11, 24'h000001, 24'h000002,
             32'h11111111, 32'h22222222, '0, '0);

        run1(0, 0, 1'b1, 24'h000010, 32'hDEADBEEF, '0);
        run1(0, 1, 1'b0, 24'h000010, '0, 32'hDEADBEEF);
        run1(0, 0, 1'b0, 24'h000002, '0, 32'h22222222);
        run1(0, 1, 1'b0, 24'h000001, '0, 32'h11111111);

        run1(1, 1, 1'b0, 24'h000010, '0, 32'hDEADBEEF);
        run1(1, 0, 1'b1, 24'h000030, 32'hCAFEF00D, '0);
        run1(1, 0, 1'b0, 24'h000030, '0, 32'hCAFEF00D);

        // Back-to-back writes from port 0 with req held across the ack
        @(negedge clk);
        drive(0, 0, 1'b1, 1'b1, 24'h000020, 32'hA5A5A5A5);
        t = cyc;
        expect_txn(0, 0, 1'b1, 24'h000020, 32'hA5A5A5A5, '0, t, 1'b1);
        expect_txn(0, 0, 1'b1, 24'h000021, 32'h5A5A5A5A, '0, t + 3, 1'b1);
        while (cyc < t + 2) @(negedge clk);
        drive(0, 0, 1'b1, 1'b1, 24'h000021, 32'h5A5A5A5A);
        while (cyc < t + 5) @(negedge clk);
        preq[0] = 2'b00;

        // Reset during WAIT aborts the read
        @(negedge clk);
        drive(0, 1, 1'b1, 1'b0, 24'h000010, '0);
        t = cyc;
        expect_txn(0, 1, 1'b0, 24'h000010, '0, '0, t, 1'b0);
        while (cyc < t + 3) @(negedge clk);
        reset = 1'b1;
        preq[0] = 2'b00;
        @(negedge clk);
        check_idle_zero("reset_mid_read");
        reset = 1'b0;
        rd_model[0] = '0;
        rd_model[1] = '0;
        repeat (6) @(negedge clk);

        run1(0, 1, 1'b0, 24'h000010, '0, 32'hDEADBEEF);
        both(0, 2, 1'b0, 2'b00, 24'h000002, 24'h000021,
             '0, '0, 32'h22222222, 32'h5A5A5A5A);
        run1(0, 1, 1'b0, 24'h000020, '0, 32'hA5A5A5A5);

        repeat (8) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk(acc_q[d].size() == 0, "acc_missing",
                $sformatf("dut%0d left=%0d", d, acc_q[d].size()));
            chk(ack_q[d].size() == 0, "ack_missing",
                $sformatf("dut%0d left=%0d", d, ack_q[d].size()));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: cyc=%0d reached time limit", cyc);
        $fatal(1, "watchdog");
    end

endmodule
